// File: rtl/split_solution_sampler.sv
// Pseudo-random candidate generator for a split constraint checker: fills a wide
// candidate from a Galois LFSR, samples the checker verdict and forwards hits downstream.
module split_solution_sampler #(
   parameter int unsigned VEC_W  = 232,
   parameter int unsigned LFSR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        seed,
   input  logic [15:0]        target_count,
   input  logic [31:0]        max_tries,
   output logic [VEC_W-1:0]   cand_vec,
   input  logic               sat_in,
   output logic               sol_valid,
   output logic [VEC_W-1:0]   sol_vec,
   input  logic               sol_ready,
   output logic               busy,
   output logic               done,
   output logic               exhausted,
   output logic [15:0]        accepted_count,
   output logic [31:0]        tries
);

   localparam int unsigned WORDS = (VEC_W + LFSR_W - 1) / LFSR_W;
   localparam int unsigned SH_W  = LFSR_W * WORDS;
   localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [2:0] {StIdle, StGen, StCheck, StEmit, StDone} state_e;

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [SH_W-1:0]     shreg_q, shreg_d;
   logic [CNT_W-1:0]    word_q, word_d;
   logic [31:0]         tries_q, tries_d;
   logic [15:0]         acc_q, acc_d;
   logic                exh_q, exh_d;
   logic [15:0]         target_q, target_d;
   logic [31:0]         max_q, max_d;

   // Galois step for x^32+x^22+x^2+x+1
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      if (v[0]) return (v >> 1) ^ LFSR_W'(32'h8020_0003);
      return v >> 1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         lfsr_q   <= LFSR_W'(1);
         shreg_q  <= '0;
         word_q   <= '0;
         tries_q  <= '0;
         acc_q    <= '0;
         exh_q    <= 1'b0;
         target_q <= '0;
         max_q    <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         shreg_q  <= shreg_d;
         word_q   <= word_d;
         tries_q  <= tries_d;
         acc_q    <= acc_d;
         exh_q    <= exh_d;
         target_q <= target_d;
         max_q    <= max_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      shreg_d  = shreg_q;
      word_d   = word_q;
      tries_d  = tries_q;
      acc_d    = acc_q;
      exh_d    = exh_q;
      target_d = target_q;
      max_d    = max_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               tries_d  = '0;
               acc_d    = '0;
               exh_d    = 1'b0;
               lfsr_d   = (seed == 32'd0) ? LFSR_W'(1) : LFSR_W'(seed);
               target_d = target_count;
               max_d    = max_tries;
               word_d   = '0;
               // cand_vec is deliberately left alone so a zero-target run leaves it intact
               state_d  = (target_count == 16'd0) ? StDone : StGen;
            end
         end
         StGen: begin
            shreg_d = {lfsr_q, shreg_q[SH_W-1:LFSR_W]};
            lfsr_d  = lfsr_step(lfsr_q);
            word_d  = word_q + CNT_W'(1);
            if (word_q == CNT_W'(WORDS - 1)) state_d = StCheck;
         end
         StCheck: begin
            if (tries_q != 32'hFFFF_FFFF) tries_d = tries_q + 32'd1;
            word_d = '0;
            if (sat_in) begin
               state_d = StEmit;
            end else if (max_q != 32'd0 && tries_q + 32'd1 == max_q) begin
               state_d = StDone;
               exh_d   = 1'b1;
            end else begin
               state_d = StGen;
            end
         end
         StEmit: begin
            if (sol_ready) begin
               acc_d = acc_q + 16'd1;
               // reaching the target wins over a budget exhausted on the same handshake
               if (acc_q + 16'd1 == target_q) begin
                  state_d = StDone;
                  exh_d   = 1'b0;
               end else if (max_q != 32'd0 && tries_q == max_q) begin
                  state_d = StDone;
                  exh_d   = 1'b1;
               end else begin
                  state_d = StGen;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign cand_vec       = shreg_q[VEC_W-1:0];
   assign sol_vec        = cand_vec;
   assign sol_valid      = (state_q == StEmit);
   assign busy           = (state_q == StGen) || (state_q == StCheck) || (state_q == StEmit);
   assign done           = (state_q == StDone);
   assign exhausted      = exh_q;
   assign accepted_count = acc_q;
   assign tries          = tries_q;

endmodule

// File: tb/tb_split_solution_sampler.sv
// Scoreboard bench for split_solution_sampler: stimulus pushes expected solutions,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_split_solution_sampler;

   localparam int VEC_W = 232;

   logic              clk = 1'b0;
   logic              rst, start, sat_in, sol_ready;
   logic [31:0]       seed, max_tries;
   logic [15:0]       target_count;
   logic [VEC_W-1:0]  cand_vec, sol_vec;
   logic              sol_valid, busy, done, exhausted;
   logic [15:0]       accepted_count;
   logic [31:0]       tries;

   split_solution_sampler #(.VEC_W(VEC_W), .LFSR_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .target_count(target_count),
      .max_tries(max_tries), .cand_vec(cand_vec), .sat_in(sat_in), .sol_valid(sol_valid),
      .sol_vec(sol_vec), .sol_ready(sol_ready), .busy(busy), .done(done),
      .exhausted(exhausted), .accepted_count(accepted_count), .tries(tries)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int n_hs  = 0;
   int cyc   = 0;
   int hs_cyc[$];
   logic [VEC_W-1:0] exp_q[$];
   logic [VEC_W-1:0] last_sol;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [VEC_W-1:0] e;
      if (!rst && sol_valid) begin
         check("sol_vec_eq_cand_vec", 256'(sol_vec), 256'(cand_vec));
         if (sol_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_solution", 256'(1), 256'(0));
            end else begin
               e = exp_q.pop_front();
               check("sol_vec", 256'(sol_vec), 256'(e));
            end
            last_sol = sol_vec;
            n_hs++;
            hs_cyc.push_back(cyc);
         end
      end
   end

   function automatic logic [31:0] step(input logic [31:0] v);
      if (v[0]) return (v >> 1) ^ 32'h8020_0003;
      return v >> 1;
   endfunction

   task automatic push_cands(input logic [31:0] sd, input int n);
      logic [31:0]  l;
      logic [255:0] sh;
      l  = (sd == 32'd0) ? 32'd1 : sd;
      sh = '0;
      for (int c = 0; c < n; c++) begin
         for (int w = 0; w < 8; w++) begin
            sh = {l, sh[255:32]};
            l  = step(l);
         end
         exp_q.push_back(sh[VEC_W-1:0]);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic kick;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      if (!done) check("timeout_done", 256'(0), 256'(1));
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!sol_valid && n < limit) begin
         tick();
         n++;
      end
      if (!sol_valid) check("timeout_sol_valid", 256'(0), 256'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs0;
      logic [VEC_W-1:0] held, s0;

      rst = 1'b1; start = 1'b0; sat_in = 1'b0; sol_ready = 1'b0;
      seed = '0; target_count = '0; max_tries = '0;
      tick(); tick();
      check("reset_busy", 256'(busy), 256'(0));
      check("reset_done", 256'(done), 256'(0));
      check("reset_sol_valid", 256'(sol_valid), 256'(0));
      check("reset_cand_vec", 256'(cand_vec), 256'(0));
      check("reset_tries", 256'(tries), 256'(0));
      check("reset_accepted", 256'(accepted_count), 256'(0));
      check("reset_exhausted", 256'(exhausted), 256'(0));
      rst = 1'b0;
      tick();

      // three hits back to back, 10 cycles per candidate
      seed = 32'd1; target_count = 16'd3; max_tries = 32'd0; sat_in = 1'b1; sol_ready = 1'b1;
      push_cands(32'd1, 3);
      hs_cyc.delete();
      kick();
      check("t1_busy", 256'(busy), 256'(1));
      wait_done(200, n);
      check("t1_done_latency", 256'(n), 256'(30));
      check("t1_tries", 256'(tries), 256'(3));
      check("t1_accepted", 256'(accepted_count), 256'(3));
      check("t1_exhausted", 256'(exhausted), 256'(0));
      check("t1_handshakes", 256'(hs_cyc.size()), 256'(3));
      if (hs_cyc.size() == 3) begin
         check("t1_spacing_a", 256'(hs_cyc[1] - hs_cyc[0]), 256'(10));
         check("t1_spacing_b", 256'(hs_cyc[2] - hs_cyc[1]), 256'(10));
      end

      // no hits: budget of 5 exhausts after 5*9 cycles
      sat_in = 1'b0; target_count = 16'd2; max_tries = 32'd5; seed = 32'h1234_5678;
      hs0 = n_hs;
      kick();
      wait_done(200, n);
      check("t2_done_latency", 256'(n), 256'(45));
      check("t2_exhausted", 256'(exhausted), 256'(1));
      check("t2_tries", 256'(tries), 256'(5));
      check("t2_accepted", 256'(accepted_count), 256'(0));
      check("t2_no_solutions", 256'(n_hs - hs0), 256'(0));

      // downstream stall for 4 EMIT cycles
      seed = 32'hDEAD_BEEF; target_count = 16'd1; max_tries = 32'd0; sat_in = 1'b1;
      sol_ready = 1'b0;
      push_cands(32'hDEAD_BEEF, 1);
      kick();
      wait_valid(50, n);
      check("t3_emit_latency", 256'(n), 256'(9));
      held = sol_vec;
      for (int k = 0; k < 4; k++) begin
         check("t3_hold_valid", 256'(sol_valid), 256'(1));
         check("t3_hold_vec", 256'(sol_vec), 256'(held));
         check("t3_hold_accepted", 256'(accepted_count), 256'(0));
         tick();
      end
      sol_ready = 1'b1;
      tick();
      check("t3_accepted", 256'(accepted_count), 256'(1));
      check("t3_valid_drop", 256'(sol_valid), 256'(0));
      check("t3_done", 256'(done), 256'(1));

      // seed 0 behaves as seed 1
      seed = 32'd0;
      push_cands(32'd0, 1);
      kick();
      wait_done(50, n);
      s0 = last_sol;
      seed = 32'd1;
      push_cands(32'd1, 1);
      kick();
      wait_done(50, n);
      check("t4_seed0_eq_seed1", 256'(s0), 256'(last_sol));
      check("t4_word0", 256'(s0[31:0]), 256'(32'h0000_0001));
      check("t4_word1", 256'(s0[63:32]), 256'(32'h8020_0003));
      check("t4_word2", 256'(s0[95:64]), 256'(32'hC030_0002));

      // zero target finishes at once and leaves the candidate alone
      held = cand_vec;
      target_count = 16'd0;
      kick();
      check("t5_done", 256'(done), 256'(1));
      check("t5_busy", 256'(busy), 256'(0));
      check("t5_tries", 256'(tries), 256'(0));
      check("t5_accepted", 256'(accepted_count), 256'(0));
      check("t5_cand_unchanged", 256'(cand_vec), 256'(held));

      // reset in EMIT drops the pending solution; rerun reproduces it
      seed = 32'h0000_ACE1; target_count = 16'd1; sat_in = 1'b1; sol_ready = 1'b0;
      push_cands(32'h0000_ACE1, 1);
      kick();
      wait_valid(50, n);
      held = sol_vec;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_valid", 256'(sol_valid), 256'(0));
      check("t6_rst_cand", 256'(cand_vec), 256'(0));
      check("t6_rst_tries", 256'(tries), 256'(0));
      check("t6_rst_busy", 256'(busy), 256'(0));
      check("t6_rst_done", 256'(done), 256'(0));
      exp_q.delete();
      push_cands(32'h0000_ACE1, 1);
      sol_ready = 1'b1;
      kick();
      wait_done(50, n);
      check("t6_rerun_accepted", 256'(accepted_count), 256'(1));
      check("t6_rerun_same_vec", 256'(last_sol), 256'(held));

      // target reached on the handshake that also spends the budget
      seed = 32'd7; target_count = 16'd2; max_tries = 32'd2; sat_in = 1'b1; sol_ready = 1'b1;
      push_cands(32'd7, 2);
      kick();
      wait_done(100, n);
      check("t7_done_latency", 256'(n), 256'(20));
      check("t7_exhausted", 256'(exhausted), 256'(0));
      check("t7_tries", 256'(tries), 256'(2));
      check("t7_accepted", 256'(accepted_count), 256'(2));

      tick();
      check("queue_drained", 256'(exp_q.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/split_solution_sampler.md
Name: split_solution_sampler

Overview:
- Upstream stimulus stage for a split constraint-checker block.
- Generates pseudo-random candidate assignments for the checker's packed variable vector and presents each candidate to the checker.
- Samples the checker's 1-bit satisfaction output for each candidate.
- Forwards satisfying candidates downstream over a valid/ready handshake; stops on a target solution count or a try budget.

Parameters:
- VEC_W, 232, width of the packed candidate vector; var_0 at the LSBs, higher-numbered variables at higher bits.
- LFSR_W, 32, LFSR width; fixed at 32 in this revision.
- WORDS, ceil(VEC_W/32) = 8, LFSR words per candidate; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- seed  in  32  LFSR seed; loaded on an accepted start.
- target_count  in  16  solutions required; 0 means finish immediately.
- max_tries  in  32  candidate budget; 0 means unlimited.
- cand_vec  out  VEC_W  candidate driven to the checker; registered.
- sat_in  in  1  checker result for the current cand_vec; combinational from the checker.
- sol_valid  out  1  satisfying candidate available.
- sol_vec  out  VEC_W  satisfying candidate; equals cand_vec while sol_valid is high.
- sol_ready  in  1  downstream accepts sol_vec.
- busy  out  1  high in GEN, CHECK and EMIT.
- done  out  1  run finished; held high until the next start.
- exhausted  out  1  run ended on max_tries before reaching target_count.
- accepted_count  out  16  solutions handed off in this run.
- tries  out  32  candidates checked in this run.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including cand_vec.
  - The LFSR is set to 1.
  - Reset wins over every other event, including mid-handshake; an un-accepted solution is dropped.
- LFSR:
  - Galois form, polynomial x^32+x^22+x^2+x+1.
  - Step: if lfsr[0]=1 then lfsr=(lfsr>>1)^0x80200003, else lfsr=lfsr>>1.
  - A seed of 0 is loaded as 1.
- Candidate register:
  - Shift register of 32*WORDS bits.
  - Each GEN cycle: shreg = {lfsr, shreg[32*WORDS-1:32]}, then the LFSR steps.
  - cand_vec = shreg[VEC_W-1:0]; unused upper bits are ignored.
- IDLE / DONE states:
  - start=1 clears tries, accepted_count, done and exhausted, and loads the LFSR.
  - If target_count=0: go to DONE with done=1, tries=0, and no candidates generated.
  - Otherwise go to GEN with the word counter set to 0.
  - start while busy is ignored.
- GEN: runs exactly WORDS cycles, then goes to CHECK. cand_vec is valid from the first CHECK cycle onward.
- CHECK (1 cycle):
  - Sample sat_in and increment tries.
  - If sat_in=1: go to EMIT.
  - Else if max_tries!=0 and tries+1==max_tries: go to DONE with exhausted=1.
  - Else: go to GEN.
- EMIT:
  - sol_valid=1; sol_vec and cand_vec are held stable until sol_valid && sol_ready.
  - On handshake, accepted_count increments and sol_valid drops in the next cycle.
  - If accepted_count+1==target_count: go to DONE with exhausted=0.
  - Else if max_tries!=0 and tries==max_tries: go to DONE with exhausted=1.
  - Else: go to GEN.
  - sol_ready outside EMIT is ignored.
- Latency:
  - Start edge to first CHECK cycle: WORDS cycles.
  - Minimum per candidate: WORDS+1 cycles when unsatisfying, WORDS+2 cycles when satisfying with sol_ready=1.
- Counters:
  - tries saturates at 2^32-1.
  - accepted_count cannot exceed target_count.
  - When target is reached on the same handshake that exhausts the budget, the result is done=1, exhausted=0 (target has priority).
- done=1 exactly when the state is DONE; busy=0 in IDLE and DONE.

Test Plan:
- sat_in tied 1, target_count=3, max_tries=0, sol_ready=1, seed=1 -> three sol_valid pulses 10 cycles apart; done rises 30 cycles after start; tries=3; accepted_count=3; exhausted=0.
- sat_in tied 0, target_count=2, max_tries=5 -> no sol_valid; done with exhausted=1 and tries=5 after 5*9=45 cycles.
- sat_in=1, sol_ready held low 4 cycles in EMIT -> sol_valid and sol_vec stable for all 4 cycles; accepted_count increments only on the cycle sol_ready rises.
- seed=0 vs seed=1, sat_in=1, target_count=1 -> identical sol_vec; first LFSR word shifted in is 0x00000001.
- target_count=0 with start -> done=1 next cycle; tries=0; cand_vec unchanged.
- rst asserted in EMIT, then start with the same seed -> outputs cleared on the reset edge; the rerun reproduces the identical first sol_vec.
